// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file dump reader.
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int ZERO_REG   = 31;
    localparam int CNT_W      = ADDR_W + 1;

    typedef logic [ADDR_W-1:0]     reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_word_t;
    typedef logic [CNT_W-1:0]      reg_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } dump_state_t;

    // Requests longer than the file itself are trimmed to one full pass.
    function automatic reg_cnt_t clamp_count(input reg_cnt_t c);
        if (c > reg_cnt_t'(NUM_REGS))
            return reg_cnt_t'(NUM_REGS);
        else
            return c;
    endfunction

endpackage

// File: rtl/dump_pair_buffer.sv
// Two-entry holding register for a fetched register pair; slot 0 is presented before slot 1.
module dump_pair_buffer
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  logic      load_second,
    input  reg_word_t load_data0,
    input  reg_word_t load_data1,
    input  reg_idx_t  load_reg0,
    input  reg_idx_t  load_reg1,
    input  logic      pop,
    output logic      front_valid,
    output reg_word_t front_data,
    output reg_idx_t  front_reg,
    output logic      front_is_last
);

    reg_word_t  data_q [2];
    reg_idx_t   reg_q  [2];
    logic [1:0] valid_q;
    logic       sel;

    assign sel           = ~valid_q[0];
    assign front_valid   = |valid_q;
    assign front_data    = data_q[sel];
    assign front_reg     = reg_q[sel];
    assign front_is_last = ~(valid_q[0] & valid_q[1]);

    // A load always wins over a pop: the pop and refill of the last entry share one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 2'b00;
            data_q[0] <= '0;
            data_q[1] <= '0;
            reg_q[0]  <= '0;
            reg_q[1]  <= '0;
        end else if (load) begin
            valid_q   <= {load_second, 1'b1};
            data_q[0] <= load_data0;
            data_q[1] <= load_data1;
            reg_q[0]  <= load_reg0;
            reg_q[1]  <= load_reg1;
        end else if (pop) begin
            valid_q[sel] <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a range of registers through the file's two read ports and streams them out.
// Optional build macro REGDUMP_CHECKSUM_EN adds an XOR checksum output of the streamed words.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_reg,
    input  logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     ReadRegister1,
    output logic [ADDR_W-1:0]     ReadRegister2,
    input  logic [DATA_WIDTH-1:0] ReadData1,
    input  logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]     out_reg,
    output logic                  out_last
`ifdef REGDUMP_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    dump_state_t state_q, state_d;
    reg_idx_t    idx_q;
    reg_idx_t    idx_odd;
    reg_cnt_t    rem_q;
    logic        accept;
    logic        handshake;
    logic        fetch;
    logic        front_valid;
    logic        front_is_last;
    reg_word_t   front_data;
    reg_idx_t    front_reg;

    assign idx_odd   = idx_q + reg_idx_t'(1);
    assign accept    = (state_q == IDLE) && start;
    assign out_valid = (state_q == DRAIN) && front_valid;
    assign handshake = out_valid && out_ready;
    assign out_data  = out_valid ? front_data : '0;
    assign out_reg   = out_valid ? front_reg : '0;
    assign out_last  = out_valid && front_is_last && (rem_q == '0);

    // The next pair is read in the same cycle the last buffered word leaves, so the stream has no bubble.
    assign fetch = (state_q == FETCH) || (handshake && front_is_last && (rem_q != '0));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = (count == '0) ? FINISH : FETCH;
            end
            FETCH: begin
                busy          = 1'b1;
                ReadRegister1 = idx_q;
                ReadRegister2 = idx_odd;
                state_d       = DRAIN;
            end
            DRAIN: begin
                busy          = 1'b1;
                ReadRegister1 = idx_q;
                ReadRegister2 = idx_odd;
                if (handshake && front_is_last && (rem_q == '0))
                    state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // remaining counts registers not yet pulled into the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            rem_q <= '0;
        end else if (accept) begin
            idx_q <= start_reg;
            rem_q <= clamp_count(count);
        end else if (fetch) begin
            idx_q <= idx_q + reg_idx_t'(2);
            rem_q <= rem_q - ((rem_q == reg_cnt_t'(1)) ? reg_cnt_t'(1) : reg_cnt_t'(2));
        end
    end

    dump_pair_buffer u_pair_buffer (
        .clk           (clk),
        .reset         (reset),
        .load          (fetch),
        .load_second   (rem_q != reg_cnt_t'(1)),
        .load_data0    (ReadData1),
        .load_data1    (ReadData2),
        .load_reg0     (idx_q),
        .load_reg1     (idx_odd),
        .pop           (handshake),
        .front_valid   (front_valid),
        .front_data    (front_data),
        .front_reg     (front_reg),
        .front_is_last (front_is_last)
    );

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (handshake)
            checksum <= checksum ^ out_data;
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader against a list-based model of the dump.
`timescale 1ns/1ps
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_reg = '0;
    logic [5:0]  count = '0;
    logic        busy, done, out_valid, out_last;
    logic        out_ready = 1'b0;
    logic [4:0]  ReadRegister1, ReadRegister2, out_reg;
    logic [63:0] ReadData1, ReadData2, out_data;
`ifdef REGDUMP_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    logic [63:0] rf [32];

    assign ReadData1 = rf[ReadRegister1];
    assign ReadData2 = rf[ReadRegister2];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_reg     (start_reg),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_reg       (out_reg),
        .out_last      (out_last)
`ifdef REGDUMP_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;

    int          got_reg   [$];
    logic [63:0] got_data  [$];
    logic        got_last  [$];
    int          got_cycle [$];
    int          exp_reg   [$];
    logic [63:0] exp_data  [$];
    logic [63:0] exp_xor;
    int          done_cycle, first_valid, stable_err;
    logic        busy_c1, busy_at_done;

    task automatic preload_plan();
        for (int i = 0; i < 32; i++)
            rf[i] = (i == 31) ? 64'h0 : 64'h100 + 64'(i);
    endtask

    // Reference: the dump is the registers start, start+1, ... modulo 32, at most 32 of them.
    task automatic build_expected(input int s, input int c);
        int n;
        exp_reg.delete();
        exp_data.delete();
        exp_xor = '0;
        n = (c > 32) ? 32 : c;
        for (int k = 0; k < n; k++) begin
            exp_reg.push_back((s + k) % 32);
            exp_data.push_back(rf[(s + k) % 32]);
            exp_xor ^= rf[(s + k) % 32];
        end
    endtask

    // Runs one dump and records what the consumer saw; ready_mode 0=always, 1=toggle, 2=random.
    task automatic do_dump(input int s, input int c, input int ready_mode, input bit poke);
        int          cycle;
        logic        p_valid, p_hs, p_last;
        logic [63:0] p_data;
        int          p_reg;
        got_reg.delete();
        got_data.delete();
        got_last.delete();
        got_cycle.delete();
        done_cycle   = -1;
        first_valid  = -1;
        stable_err   = 0;
        busy_c1      = 1'b0;
        busy_at_done = 1'b1;
        p_valid      = 1'b0;
        p_hs         = 1'b0;
        p_last       = 1'b0;
        p_data       = '0;
        p_reg        = 0;
        @(negedge clk);
        start     = 1'b1;
        start_reg = 5'(s);
        count     = 6'(c);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cycle = 1; cycle < 400; cycle++) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cycle[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (cycle >= 2) && (cycle <= 3);
            if (start) begin
                start_reg = 5'($urandom);
                count     = 6'($urandom_range(1, 63));
            end
            if (cycle == 1)
                busy_c1 = busy;
            if (done) begin
                done_cycle   = cycle;
                busy_at_done = busy;
                break;
            end
            if (p_valid && !p_hs &&
                (!out_valid || out_data !== p_data || out_reg !== 5'(p_reg) || out_last !== p_last))
                stable_err++;
            if (out_valid && first_valid < 0)
                first_valid = cycle;
            if (out_valid && out_ready) begin
                got_reg.push_back(int'(out_reg));
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cycle.push_back(cycle);
            end
            p_valid = out_valid;
            p_hs    = out_valid && out_ready;
            p_data  = out_data;
            p_reg   = int'(out_reg);
            p_last  = out_last;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b valid=%b last=%b, want all 0", busy, done, out_valid, out_last);
        end
        vectors++;
        if (out_data !== 64'h0 || out_reg !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: data=%h reg=%0d, want 0/0", out_data, out_reg);
        end
        vectors++;
        if (ReadRegister1 !== 5'd0 || ReadRegister2 !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rr: rr1=%0d rr2=%0d, want 0/0", ReadRegister1, ReadRegister2);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        preload_plan();
        build_expected(0, 4);
        do_dump(0, 4, 0, 1'b0);
        vectors++;
        if (got_reg.size() !== exp_reg.size()) begin
            miscompares++;
            $display("[TB] FAIL basic_words: got %0d want %0d", got_reg.size(), exp_reg.size());
        end else begin
            for (int k = 0; k < exp_reg.size(); k++) begin
                vectors++;
                if (got_reg[k] !== exp_reg[k] || got_data[k] !== exp_data[k] ||
                    got_last[k] !== (k == exp_reg.size() - 1) || got_cycle[k] !== 2 + k) begin
                    miscompares++;
                    $display("[TB] FAIL basic_word%0d: got reg %0d data %h last %b cyc %0d, want reg %0d data %h last %b cyc %0d",
                             k, got_reg[k], got_data[k], got_last[k], got_cycle[k],
                             exp_reg[k], exp_data[k], (k == exp_reg.size() - 1), 2 + k);
                end
            end
        end
        vectors++;
        if (first_valid !== 2) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: first valid at %0d want 2", first_valid);
        end
        vectors++;
        if (done_cycle !== 6 || busy_at_done !== 1'b0 || busy_c1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_done: done at %0d busy_done %b busy1 %b, want 6/0/1", done_cycle, busy_at_done, busy_c1);
        end
        @(negedge clk);
        vectors++;
        if (ReadRegister1 !== 5'd0 || ReadRegister2 !== 5'd0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_rr: rr1=%0d rr2=%0d done=%b, want 0/0/0", ReadRegister1, ReadRegister2, done);
        end
    endtask

    task automatic test_wrap();
        preload_plan();
        build_expected(30, 3);
        do_dump(30, 3, 0, 1'b0);
        vectors++;
        if (got_reg.size() !== 3) begin
            miscompares++;
            $display("[TB] FAIL wrap_words: got %0d want 3", got_reg.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got_reg[k] !== exp_reg[k] || got_data[k] !== exp_data[k] || got_last[k] !== (k == 2)) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_word%0d: got reg %0d data %h last %b, want reg %0d data %h last %b",
                             k, got_reg[k], got_data[k], got_last[k], exp_reg[k], exp_data[k], (k == 2));
                end
            end
        end
        vectors++;
        if (done_cycle < 0 || done_cycle !== got_cycle[got_cycle.size() - 1] + 1) begin
            miscompares++;
            $display("[TB] FAIL wrap_done: done at %0d, want one cycle after last word", done_cycle);
        end
    endtask

    task automatic test_clamp();
        preload_plan();
        build_expected(0, 40);
        do_dump(0, 40, 0, 1'b0);
        vectors++;
        if (got_reg.size() !== 32) begin
            miscompares++;
            $display("[TB] FAIL clamp_words: got %0d want 32", got_reg.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                vectors++;
                if (got_reg[k] !== exp_reg[k] || got_data[k] !== exp_data[k] ||
                    got_last[k] !== (k == 31) || got_cycle[k] !== 2 + k) begin
                    miscompares++;
                    $display("[TB] FAIL clamp_word%0d: got reg %0d data %h last %b cyc %0d, want reg %0d data %h cyc %0d",
                             k, got_reg[k], got_data[k], got_last[k], got_cycle[k], exp_reg[k], exp_data[k], 2 + k);
                end
            end
        end
        vectors++;
        if (done_cycle !== 34) begin
            miscompares++;
            $display("[TB] FAIL clamp_done: done at %0d want 34", done_cycle);
        end
`ifdef REGDUMP_CHECKSUM_EN
        vectors++;
        if (checksum !== exp_xor) begin
            miscompares++;
            $display("[TB] FAIL clamp_checksum: got %h want %h", checksum, exp_xor);
        end
`endif
    endtask

    task automatic test_backpressure();
        preload_plan();
        build_expected(5, 2);
        do_dump(5, 2, 1, 1'b1);
        vectors++;
        if (got_reg.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL bp_words: got %0d want 2", got_reg.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (got_reg[k] !== exp_reg[k] || got_data[k] !== exp_data[k] || got_last[k] !== (k == 1)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_word%0d: got reg %0d data %h last %b, want reg %0d data %h last %b",
                             k, got_reg[k], got_data[k], got_last[k], exp_reg[k], exp_data[k], (k == 1));
                end
            end
        end
        vectors++;
        if (stable_err !== 0 || done_cycle < 0) begin
            miscompares++;
            $display("[TB] FAIL bp_stable: %0d unstable cycles, done at %0d, want 0 and done seen", stable_err, done_cycle);
        end
    endtask

    task automatic test_random();
        int s, c;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++)
                rf[i] = {$urandom, $urandom};
            s = $urandom_range(0, 31);
            c = $urandom_range(0, 63);
            build_expected(s, c);
            do_dump(s, c, 2, 1'($urandom_range(0, 1)));
            vectors++;
            if (got_reg.size() !== exp_reg.size() || done_cycle < 0 || stable_err !== 0) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_words: got %0d words done %0d unstable %0d, want %0d words (s=%0d c=%0d)",
                         it, got_reg.size(), done_cycle, stable_err, exp_reg.size(), s, c);
            end else begin
                for (int k = 0; k < exp_reg.size(); k++) begin
                    vectors++;
                    if (got_reg[k] !== exp_reg[k] || got_data[k] !== exp_data[k] ||
                        got_last[k] !== (k == exp_reg.size() - 1)) begin
                        miscompares++;
                        $display("[TB] FAIL rand%0d_word%0d: got reg %0d data %h last %b, want reg %0d data %h",
                                 it, k, got_reg[k], got_data[k], got_last[k], exp_reg[k], exp_data[k]);
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            vectors++;
            if (checksum !== exp_xor) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_checksum: got %h want %h", it, checksum, exp_xor);
            end
`endif
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        preload_plan();
        @(negedge clk);
        start     = 1'b1;
        start_reg = 5'd10;
        count     = 6'd12;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_pre: out_valid=%b want 1 mid-dump", out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_state: busy=%b valid=%b done=%b last=%b, want all 0", busy, out_valid, done, out_last);
        end
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || out_valid)
                seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: %0d cycles with done/valid, want 0", seen);
        end
        do_dump(3, 0, 0, 1'b0);
        vectors++;
        if (done_cycle !== 1 || got_reg.size() !== 0 || first_valid !== -1) begin
            miscompares++;
            $display("[TB] FAIL zero_count: done at %0d words %0d first valid %0d, want 1/0/-1",
                     done_cycle, got_reg.size(), first_valid);
        end
`ifdef REGDUMP_CHECKSUM_EN
        vectors++;
        if (checksum !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_checksum: got %h want 0", checksum);
        end
`endif
    endtask

    initial begin
        preload_plan();
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_backpressure();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
